// File: rtl/dpb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : dpb_pkg
// Description : Shared constants, clear-FSM state encoding and byte-merge
//               helper for the dpb_pipe dual-port buffer.
// Revision    : 1.0 - initial release
// =============================================================================
package dpb_pkg;

    localparam int WRITE_FIRST      = 0;
    localparam int READ_FIRST       = 1;
    localparam int MAX_READ_LATENCY = 4;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t ST_IDLE_RST = 2'd0;
    localparam clr_state_t ST_CLEAR    = 2'd1;
    localparam clr_state_t ST_RUN      = 2'd2;

    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage : dpb_pkg
`default_nettype wire

// File: rtl/dpb_rd_pipe.sv
`default_nettype none
// =============================================================================
// Module      : dpb_rd_pipe
// Description : Extra read-latency stages (data + valid) for one RAM port.
// Revision    : 1.0 - initial release
// =============================================================================
module dpb_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [DATA_WIDTH-1:0] data_d [STAGES];
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     valid_d;

    // Data only advances alongside a valid beat, so the last stage holds its value.
    always_comb begin
        valid_d   = STAGES'({valid_q, i_valid});
        data_d[0] = i_valid ? i_data : data_q[0];
        for (int i = 1; i < STAGES; i++) begin
            data_d[i] = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign o_data  = data_q[STAGES-1];
    assign o_valid = valid_q[STAGES-1];

endmodule : dpb_rd_pipe
`default_nettype wire

// File: rtl/dpb_pipe.sv
`default_nettype none
// =============================================================================
// Module      : dpb_pipe
// Description : True dual-port RAM with byte enables, pipelined read latency,
//               write-first/read-first modes, collision flag and clear sweep.
// Revision    : 1.0 - initial release
// =============================================================================
module dpb_pipe
    import dpb_pkg::*;
#(
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        ADDR_WIDTH     = 10,
    parameter int                        READ_LATENCY   = 1,
    parameter int                        WRITE_MODE     = 0,
    parameter int                        CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    output logic                      collision,
    input  logic                      a_en,
    input  logic [DATA_WIDTH/8-1:0]   a_we,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0]     a_din,
    output logic [DATA_WIDTH-1:0]     a_dout,
    output logic                      a_valid,
    input  logic                      b_en,
    input  logic [DATA_WIDTH/8-1:0]   b_we,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0]     b_din,
    output logic [DATA_WIDTH-1:0]     b_dout,
    output logic                      b_valid
);

    localparam int                    BE_WIDTH  = DATA_WIDTH / 8;
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < BE_WIDTH; i++) begin
            res[i*8 +: 8] = merge_byte(old_w[i*8 +: 8], new_w[i*8 +: 8], be[i]);
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_we;

    logic                  a_acc, b_acc, a_wr, b_wr, same_addr;
    logic [DATA_WIDTH-1:0] a_old, b_old, ab_word, a_new, b_new;
    logic [DATA_WIDTH-1:0] a_data1_q, a_data1_d, b_data1_q, b_data1_d;
    logic                  a_val1_q, a_val1_d, b_val1_q, b_val1_d;
    logic                  collision_q, collision_d;

    // The sweep writes address 0 on the very first edge after reset release.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_IDLE_RST, ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we     = ~rst;
                    clr_addr_d = clr_addr_q + 1'b1;
                    state_d    = (clr_addr_q == LAST_ADDR) ? ST_RUN : ST_CLEAR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE_RST;
        endcase
    end

    assign ready = (state_q == ST_RUN);

    always_comb begin
        a_acc     = a_en & ready & ~rst;
        b_acc     = b_en & ready & ~rst;
        a_wr      = a_acc & (|a_we);
        b_wr      = b_acc & (|b_we);
        same_addr = (a_addr == b_addr);
        a_old     = mem[a_addr];
        b_old     = mem[b_addr];
        // On a shared address A's bytes override B's; both ports see the combined word.
        ab_word   = merge_word(merge_word(a_old, b_din, b_we), a_din, a_we);
        a_new     = (b_wr && same_addr) ? ab_word : merge_word(a_old, a_din, a_we);
        b_new     = (a_wr && same_addr) ? ab_word : merge_word(b_old, b_din, b_we);

        a_val1_d  = a_acc;
        b_val1_d  = b_acc;
        a_data1_d = a_data1_q;
        b_data1_d = b_data1_q;
        if (a_acc) begin
            a_data1_d = (a_wr && WRITE_MODE == WRITE_FIRST) ? a_new : a_old;
        end
        if (b_acc) begin
            b_data1_d = (b_wr && WRITE_MODE == WRITE_FIRST) ? b_new : b_old;
        end
        collision_d = a_wr & b_wr & same_addr & (|(a_we & b_we));
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end else begin
            if (a_wr) mem[a_addr] <= a_new;
            if (b_wr) mem[b_addr] <= b_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE_RST;
            clr_addr_q  <= '0;
            a_data1_q   <= '0;
            b_data1_q   <= '0;
            a_val1_q    <= 1'b0;
            b_val1_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            a_data1_q   <= a_data1_d;
            b_data1_q   <= b_data1_d;
            a_val1_q    <= a_val1_d;
            b_val1_q    <= b_val1_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

    if (READ_LATENCY > 1) begin : g_pipe
        dpb_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (READ_LATENCY - 1)
        ) u_a_pipe (
            .clk     (clk),
            .rst     (rst),
            .i_data  (a_data1_q),
            .i_valid (a_val1_q),
            .o_data  (a_dout),
            .o_valid (a_valid)
        );
        dpb_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (READ_LATENCY - 1)
        ) u_b_pipe (
            .clk     (clk),
            .rst     (rst),
            .i_data  (b_data1_q),
            .i_valid (b_val1_q),
            .o_data  (b_dout),
            .o_valid (b_valid)
        );
    end else begin : g_direct
        assign a_dout  = a_data1_q;
        assign a_valid = a_val1_q;
        assign b_dout  = b_data1_q;
        assign b_valid = b_val1_q;
    end

endmodule : dpb_pipe
`default_nettype wire
